// File: rtl/vga_frame_monitor.sv
// Receiver for an hs/vs/vde + RGB444 pixel stream: checks per-frame timing against the
// configured geometry, CRC-16/CCITT's every active pixel and publishes one result set per frame.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        vde,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        frame_done,
  output logic [15:0] frame_crc,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas,
  output logic [3:0]  err_flags,
  output logic        frame_ok,
  output logic [15:0] frame_count
);

  localparam logic [9:0]  H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT = 10'(V_TOTAL);

  typedef enum logic {HUNT, CAPTURE} state_t;
  state_t state, state_nx;

  logic        hs_q, vs_q, vde_q;
  logic        hs_fall, vs_fall, vde_fall;
  logic [15:0] crc, crc_nx;
  logic [9:0]  h_cnt, h_cnt_nx, v_cnt, v_cnt_nx, h_last, h_last_nx, hs_lines, hs_lines_nx;
  logic [10:0] hs_per, hs_per_nx;
  logic        hs_seen, hs_seen_nx;
  logic        err_line, err_line_nx, err_hper, err_hper_nx;
  logic        frame_start;
  logic        publish;
  logic [15:0] pub_crc;
  logic [9:0]  pub_h, pub_v;
  logic [3:0]  pub_err;

  assign hs_fall  = hs_q  & ~hs;
  assign vs_fall  = vs_q  & ~vs;
  assign vde_fall = vde_q & ~vde;

  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    logic [11:0] w;
    r = c;
    w = d;
    for (int unsigned i = 0; i < 12; i++) begin
      r = (r[15] ^ w[11]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      w = {w[10:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [9:0] sat10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  always_comb begin
    state_nx    = state;
    crc_nx      = crc;
    h_cnt_nx    = h_cnt;
    v_cnt_nx    = v_cnt;
    h_last_nx   = h_last;
    hs_lines_nx = hs_lines;
    hs_per_nx   = hs_per;
    hs_seen_nx  = hs_seen;
    err_line_nx = err_line;
    err_hper_nx = err_hper;
    frame_start = 1'b0;
    publish     = 1'b0;
    pub_crc     = crc;
    pub_h       = h_last;
    pub_v       = v_cnt;
    pub_err     = '0;
    unique case (state)
      HUNT: begin
        if (vs_fall) begin
          state_nx    = CAPTURE;
          frame_start = 1'b1;
          hs_per_nx   = '0;
          hs_seen_nx  = 1'b0;
        end
      end
      CAPTURE: begin
        if (vde) begin
          crc_nx   = crc12(crc, {red, green, blue});
          h_cnt_nx = sat10(h_cnt);
        end
        if (vde_fall) begin
          if (h_cnt != H_ACT) err_line_nx = 1'b1;
          h_last_nx = h_cnt;
          v_cnt_nx  = sat10(v_cnt);
          h_cnt_nx  = '0;
        end
        hs_per_nx = (hs_per == '1) ? hs_per : hs_per + 11'd1;
        if (hs_fall) begin
          if (hs_seen && (hs_per + 11'd1 != H_TOT)) err_hper_nx = 1'b1;
          hs_seen_nx  = 1'b1;
          hs_lines_nx = sat10(hs_lines);
          hs_per_nx   = '0;
        end
        // Results are taken from the already-updated next values so that pixel, line
        // close and hs fall on the vs-fall cycle all land in the ending frame.
        if (vs_fall) begin
          publish     = 1'b1;
          frame_start = 1'b1;
          pub_crc     = crc_nx;
          pub_h       = h_last_nx;
          pub_v       = v_cnt_nx;
          pub_err     = {hs_lines_nx != V_TOT, err_hper_nx, v_cnt_nx != V_ACT, err_line_nx};
        end
      end
    endcase
    if (frame_start) begin
      crc_nx      = CRC_INIT;
      h_cnt_nx    = '0;
      v_cnt_nx    = '0;
      h_last_nx   = '0;
      hs_lines_nx = '0;
      err_line_nx = 1'b0;
      err_hper_nx = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      vde_q    <= 1'b0;
      crc      <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_last   <= '0;
      hs_lines <= '0;
      hs_per   <= '0;
      hs_seen  <= 1'b0;
      err_line <= 1'b0;
      err_hper <= 1'b0;
    end else begin
      hs_q     <= hs;
      vs_q     <= vs;
      vde_q    <= vde;
      crc      <= crc_nx;
      h_cnt    <= h_cnt_nx;
      v_cnt    <= v_cnt_nx;
      h_last   <= h_last_nx;
      hs_lines <= hs_lines_nx;
      hs_per   <= hs_per_nx;
      hs_seen  <= hs_seen_nx;
      err_line <= err_line_nx;
      err_hper <= err_hper_nx;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_crc   <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      err_flags   <= '0;
      frame_ok    <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        frame_crc   <= pub_crc;
        h_meas      <= pub_h;
        v_meas      <= pub_v;
        err_flags   <= pub_err;
        frame_ok    <= (pub_err == '0);
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a reduced geometry: frames are described at line level and
// expected results are derived from the description; outputs are compared every cycle.
module tb_vga_frame_monitor;

  localparam int HA = 16, VA = 10, HT = 24, VT = 14;
  localparam int HS_W = 2, H_START = 4, V_START = 2;

  logic        pixel_clk = 1'b0;
  logic        reset, hs, vs, vde;
  logic [3:0]  red, green, blue;
  logic        frame_done, frame_ok;
  logic [15:0] frame_crc, frame_count;
  logic [9:0]  h_meas, v_meas;
  logic [3:0]  err_flags;

  vga_frame_monitor #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .CRC_INIT(16'hFFFF)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .hs(hs), .vs(vs), .vde(vde),
    .red(red), .green(green), .blue(blue),
    .frame_done(frame_done), .frame_crc(frame_crc), .h_meas(h_meas), .v_meas(v_meas),
    .err_flags(err_flags), .frame_ok(frame_ok), .frame_count(frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int nlines; int nact; int bad_line; int bad_per; int short_line; int rst_line;
    int flip_x; int flip_y; bit zero; logic [31:0] seed;
  } frame_t;

  int vectors = 0, miscompares = 0;
  bit cmp_en = 0;

  logic        e_done, e_ok;
  logic [15:0] e_crc, e_count;
  logic [9:0]  e_h, e_v;
  logic [3:0]  e_err;

  bit          capturing = 0, first_frame = 0, pend_valid = 0;
  logic [15:0] p_crc;
  logic [9:0]  p_h, p_v;
  logic [3:0]  p_err;
  bit          fbits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      if (miscompares <= 20) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // CRC-16/CCITT over the frame's bit stream, processed one message bit at a time
  function automatic logic [15:0] crc_of_bits();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (fbits[i]) c = (c[15] ^ fbits[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [11:0] pixel_word(input frame_t f, input int x, input int y);
    logic [31:0] h;
    logic [11:0] w;
    h = f.zero ? 32'h0 : (f.seed ^ (32'(x) * 32'h9E3779B1) ^ (32'(y) * 32'h85EBCA77));
    w = f.zero ? 12'h000 : h[18:7];
    if (x == f.flip_x && y == f.flip_y) w = w ^ 12'h100;
    return w;
  endfunction

  function automatic frame_t nominal(input logic [31:0] seed, input bit zero);
    frame_t f;
    f.nlines = VT; f.nact = VA; f.bad_line = -1; f.bad_per = HT; f.short_line = -1;
    f.rst_line = -1; f.flip_x = -1; f.flip_y = -1; f.zero = zero; f.seed = seed;
    return f;
  endfunction

  always @(negedge pixel_clk) begin
    if (cmp_en) begin
      check("frame_done",  32'(frame_done),  32'(e_done));
      check("frame_crc",   32'(frame_crc),   32'(e_crc));
      check("h_meas",      32'(h_meas),      32'(e_h));
      check("v_meas",      32'(v_meas),      32'(e_v));
      check("err_flags",   32'(err_flags),   32'(e_err));
      check("frame_ok",    32'(frame_ok),    32'(e_ok));
      check("frame_count", 32'(frame_count), 32'(e_count));
    end
  end

  task automatic step(input logic rst_v, input logic hs_v, input logic vs_v, input logic vde_v,
                      input logic [11:0] w, input bit boundary);
    bit pub;
    reset = rst_v; hs = hs_v; vs = vs_v; vde = vde_v;
    {red, green, blue} = w;
    pub = 0;
    if (!rst_v && boundary) begin
      if (capturing) begin pub = pend_valid; first_frame = 0; end
      else begin capturing = 1; first_frame = 1; end
    end
    @(posedge pixel_clk); #1;
    if (rst_v) begin
      capturing = 0; pend_valid = 0;
      e_done = 0; e_crc = '0; e_h = '0; e_v = '0; e_err = '0; e_ok = 0; e_count = '0;
    end else if (pub) begin
      e_done = 1; e_crc = p_crc; e_h = p_h; e_v = p_v; e_err = p_err;
      e_ok = (p_err == 4'b0000); e_count = e_count + 16'd1;
    end else begin
      e_done = 0;
    end
  endtask

  task automatic run_frame(input frame_t f);
    int nruns, last_run, per, run;
    bit bad_run, bad_per, l0_bad, vde_v;
    logic [11:0] w, sh;
    fbits.delete();
    nruns = 0; last_run = 0; bad_run = 0; bad_per = 0; l0_bad = 0;
    for (int l = 0; l < f.nlines; l++) begin
      per = (l == f.bad_line) ? f.bad_per : HT;
      run = (l >= V_START && l < V_START + f.nact) ? ((l == f.short_line) ? HA - 1 : HA) : 0;
      if (run > 0) begin nruns++; last_run = run; if (run != HA) bad_run = 1; end
      if (per != HT) begin if (l == 0) l0_bad = 1; else bad_per = 1; end
      for (int c = 0; c < per; c++) begin
        vde_v = (c >= H_START && c < H_START + run);
        w = vde_v ? pixel_word(f, c - H_START, l - V_START) : 12'($urandom);
        if (vde_v) begin
          sh = w;
          repeat (12) begin fbits.push_back(sh[11]); sh = sh << 1; end
        end
        step(l == f.rst_line && c < 4, c >= HS_W, l >= 2, vde_v, w, l == 0 && c == 0);
      end
    end
    // A period closed by line 0's own hs fall is unmeasured right after leaving HUNT
    if (l0_bad && !first_frame) bad_per = 1;
    if (capturing) begin
      p_crc = crc_of_bits(); p_h = 10'(last_run); p_v = 10'(nruns);
      p_err = {f.nlines != VT, bad_per, nruns != VA, bad_run};
      pend_valid = 1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, expected completion before timeout");
    $fatal(1);
  end

  initial begin
    frame_t f;
    string s;
    byte ch;
    logic [31:0] sd;
    reset = 1; hs = 1; vs = 1; vde = 0; {red, green, blue} = '0;

    s = "123456789";
    fbits.delete();
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      repeat (8) begin fbits.push_back(ch[7]); ch = ch << 1; end
    end
    check("crc_model_check_string", 32'(crc_of_bits()), 32'h29B1);

    step(1, 1, 1, 0, 12'h000, 0);
    cmp_en = 1;
    repeat (7) step(1, 1, 1, 0, 12'h000, 0);
    repeat (4) step(0, 1, 1, 0, 12'h000, 0);

    // first vs fall only arms the monitor
    run_frame(nominal(0, 1));
    check("hunt_frame_count", 32'(frame_count), 32'd0);
    run_frame(nominal(0, 1));
    check("zero_h_meas", 32'(h_meas), 32'(HA));
    check("zero_v_meas", 32'(v_meas), 32'(VA));
    check("zero_err", 32'(err_flags), 32'd0);
    check("zero_ok", 32'(frame_ok), 32'd1);
    check("zero_count", 32'(frame_count), 32'd1);

    f = nominal($urandom, 0); f.short_line = 5;
    run_frame(f);
    run_frame(nominal($urandom, 0));
    check("short_line_err", 32'(err_flags), 32'b0001);
    check("short_line_ok", 32'(frame_ok), 32'd0);
    run_frame(nominal($urandom, 0));
    check("recover_err", 32'(err_flags), 32'd0);
    check("recover_ok", 32'(frame_ok), 32'd1);

    f = nominal($urandom, 0); f.bad_line = 6; f.bad_per = HT + 1;
    run_frame(f);
    run_frame(nominal($urandom, 0));
    check("long_line_err", 32'(err_flags), 32'b0100);
    f = nominal($urandom, 0); f.nact = VA + 1;
    run_frame(f);
    run_frame(nominal($urandom, 0));
    check("extra_line_err", 32'(err_flags), 32'b0010);
    check("extra_line_v_meas", 32'(v_meas), 32'(VA + 1));

    f = nominal($urandom, 0); f.rst_line = 5;
    run_frame(f);
    check("reset_count", 32'(frame_count), 32'd0);
    run_frame(nominal($urandom, 0));
    check("rearm_count", 32'(frame_count), 32'd0);
    run_frame(nominal($urandom, 0));
    check("after_reset_count", 32'(frame_count), 32'd1);

    sd = $urandom;
    run_frame(nominal(sd, 0));
    f = nominal(sd, 0); f.flip_x = 5; f.flip_y = 7;
    run_frame(f);
    run_frame(nominal(sd, 0));
    run_frame(nominal(sd, 0));

    for (int k = 0; k < 12; k++) begin
      f = nominal($urandom, 0);
      case ($urandom_range(0, 5))
        1: f.nlines = VT - 1 + 2 * int'($urandom_range(0, 1));
        2: f.nact = VA - 1 + 2 * int'($urandom_range(0, 1));
        3: begin
          f.bad_line = int'($urandom_range(0, VT - 1));
          f.bad_per = HT - 1 + 2 * int'($urandom_range(0, 1));
        end
        4: f.short_line = V_START + int'($urandom_range(0, VA - 1));
        default: ;
      endcase
      run_frame(f);
    end
    run_frame(nominal($urandom, 0));
    repeat (3) step(0, 1, 1, 0, 12'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
